alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Byte-serial sequencer for the shared 8-bit ALU datapath (A, B, S1, S0, Cin → F, Cout). It accepts one multi-byte operation through a valid/ready request port and drives the ALU one byte lane per cycle, LSB first. Between lanes it carries the ALU carry-out into the next lane's Cin. The assembled multi-precision result is returned on a valid/ready response port. The block sits between the instruction/control logic and the single ALU instance, and lets the 8-bit ALU serve 16/32/64-bit operations.

## Interface
- NBYTES, 4, operand width in bytes; legal 1..8; W = 8*NBYTES
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_op  in  2  {S1,S0} function code applied to every lane
- req_cin  in  1  carry-in for lane 0
- req_a  in  W  operand A
- req_b  in  W  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_f  out  W  result
- rsp_cout  out  1  carry-out of top lane
- busy  out  1  state ≠ IDLE
- alu_a  out  8  ALU operand A lane
- alu_b  out  8  ALU operand B lane
- alu_s1, alu_s0  out  1 each  ALU function select
- alu_cin  out  1  ALU carry-in
- alu_f  in  8  ALU result (combinational from alu_* outputs)
- alu_cout  in  1  ALU carry-out

## Operation
- ALU functions per lane (9-bit sum): 00 A+B+Cin; 01 A+Cin; 10 ~B+Cin; 11 A+~B+Cin. Because carry ripples across lanes, these become multi-precision add, increment, negate (Cin=1) and subtract (Cin=1).
- FSM states IDLE, EXEC, DONE.
  - IDLE: req_ready=1. On req_valid: latch req_a/req_b into shift registers, latch op, set the carry register to req_cin, set lane=0, go to EXEC.
  - EXEC: alu_a/alu_b = low byte of the shift registers, {alu_s1,alu_s0}=op, alu_cin=carry register. At each clock edge: alu_f is written to result byte[lane], carry register ← alu_cout, operands shift right 8, lane++. After lane NBYTES-1, go to DONE.
  - DONE: rsp_valid=1. rsp_f and rsp_cout are held stable until rsp_valid&rsp_ready, then go to IDLE.
- In IDLE and DONE, alu_a, alu_b, alu_s1, alu_s0 and alu_cin are all 0.
- rsp_cout is the carry register after the last lane.
- Lane counter width is 3 bits. It does not wrap within an operation.
- Reset, including mid-EXEC or mid-DONE: state goes to IDLE immediately. The in-flight operation is discarded and no response is produced.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_f=0, rsp_cout=0, busy=0, all alu_* outputs 0.
- Request accepted at edge T. Lane k is presented to the ALU in cycle T+1+k. rsp_valid rises after edge T+NBYTES, so latency is NBYTES+1 cycles.
- req_ready is 0 from T+1 until the cycle after the response handshake. No request is accepted while busy. Minimum spacing between requests is NBYTES+2 cycles.
- rsp_valid drops the cycle after the handshake. If rsp_ready is low, rsp_valid, rsp_f and rsp_cout stay unchanged indefinitely.
- The ALU is combinational; alu_f/alu_cout are sampled in the same cycle they are driven.

## Configuration
- ALU_SEQ_OVF_EN defined: adds output port rsp_ovf (out, 1), the signed overflow of the top lane.
  - x and y are the effective ALU operands of lane NBYTES-1: 00 A,B; 01 A,0; 10 ~B,0; 11 A,~B.
  - rsp_ovf = (x[7]==y[7]) && (f[7]!=x[7]).
  - rsp_ovf is registered at the last EXEC edge, resets to 0, and is held like rsp_f.
- ALU_SEQ_OVF_EN undefined: no rsp_ovf port and no overflow logic. All other behaviour is identical.

## Test plan
- Add carry ripple: NBYTES=4, op 00, A=0x000000FF, B=0x00000001, Cin=0 → rsp_f=0x00000100, rsp_cout=0. rsp_valid first seen 5 cycles after acceptance.
- Subtract borrow: op 11, Cin=1, A=0x00000000, B=0x00000001 → rsp_f=0xFFFFFFFF, rsp_cout=0. Also A=5, B=3 → rsp_f=0x00000002, rsp_cout=1.
- Negate/increment wrap: op 10, Cin=1, B=0 → rsp_f=0, rsp_cout=1. Op 01, Cin=1, A=0xFFFFFFFF → rsp_f=0, rsp_cout=1.
- Overflow (with ALU_SEQ_OVF_EN): op 00, A=0x7FFFFFFF, B=1, Cin=0 → rsp_f=0x80000000, rsp_cout=0, rsp_ovf=1. Op 00, A=B=0xFFFFFFFF → rsp_ovf=0.
- Backpressure: hold rsp_ready=0 for 3 cycles with a second req_valid asserted. Required: rsp_f/rsp_cout stable, req_ready=0, second request not accepted. After rsp_ready=1, the second request is accepted one cycle later.
- Reset mid-operation: rst_n low during lane 2 → same cycle busy=0, all alu_* outputs 0, req_ready=1. After release no rsp_valid appears, and a new request completes correctly.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer that drives a shared 8-bit ALU lane by lane, LSB first.
// Optional build macro ALU_SEQ_OVF_EN adds the rsp_ovf signed-overflow output.
module alu_seq_ctrl #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic         req_cin,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_f,
    output logic         rsp_cout,
`ifdef ALU_SEQ_OVF_EN
    output logic         rsp_ovf,
`endif
    output logic         busy,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_s1,
    output logic         alu_s0,
    output logic         alu_cin,
    input  logic [7:0]   alu_f,
    input  logic         alu_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_LANE = 3'(NBYTES - 1);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [W-1:0] a_sh_r;
    logic [W-1:0] b_sh_r;
    logic [W-1:0] res_r;
    logic [W-1:0] res_nxt_s;
    logic [W-1:0] rsp_f_r;
    logic [1:0]   op_r;
    logic         carry_r;
    logic         rsp_cout_r;
    logic [2:0]   lane_r;
    logic         last_lane_s;

`ifdef ALU_SEQ_OVF_EN
    logic         rsp_ovf_r;

    // Signed overflow of one lane from the operands the ALU effectively adds.
    function automatic logic ovf_calc(input logic [1:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] f);
        logic [7:0] x;
        logic [7:0] y;
        case (op)
            2'b00:   begin x = a;  y = b;     end
            2'b01:   begin x = a;  y = 8'h00; end
            2'b10:   begin x = ~b; y = 8'h00; end
            2'b11:   begin x = a;  y = ~b;    end
            default: begin x = a;  y = b;     end
        endcase
        return (x[7] == y[7]) && (f[7] != x[7]);
    endfunction

    assign rsp_ovf = rsp_ovf_r;
`endif

    assign last_lane_s = (lane_r == LAST_LANE);
    assign req_ready   = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign rsp_valid   = (state_r == DONE);
    assign rsp_f       = rsp_f_r;
    assign rsp_cout    = rsp_cout_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_nxt_s = EXEC;
                else           state_nxt_s = IDLE;
            end
            EXEC: begin
                if (last_lane_s) state_nxt_s = DONE;
                else             state_nxt_s = EXEC;
            end
            DONE: begin
                if (rsp_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // ALU lane drive; the ALU sees all zeros outside EXEC.
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_s1  = 1'b0;
        alu_s0  = 1'b0;
        alu_cin = 1'b0;
        if (state_r == EXEC) begin
            alu_a   = a_sh_r[7:0];
            alu_b   = b_sh_r[7:0];
            alu_s1  = op_r[1];
            alu_s0  = op_r[0];
            alu_cin = carry_r;
        end else begin
            alu_a   = 8'h00;
            alu_b   = 8'h00;
            alu_s1  = 1'b0;
            alu_s0  = 1'b0;
            alu_cin = 1'b0;
        end
    end

    // Merge the current ALU byte into the result at the active lane.
    always_comb begin
        res_nxt_s = res_r;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane_r == 3'(i)) res_nxt_s[i*8 +: 8] = alu_f;
            else                 res_nxt_s[i*8 +: 8] = res_r[i*8 +: 8];
        end
    end

    // Operand shifting, carry chaining and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r     <= {W{1'b0}};
            b_sh_r     <= {W{1'b0}};
            res_r      <= {W{1'b0}};
            rsp_f_r    <= {W{1'b0}};
            op_r       <= 2'b00;
            carry_r    <= 1'b0;
            rsp_cout_r <= 1'b0;
            lane_r     <= 3'd0;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        a_sh_r  <= req_a;
                        b_sh_r  <= req_b;
                        op_r    <= req_op;
                        carry_r <= req_cin;
                        lane_r  <= 3'd0;
                        res_r   <= {W{1'b0}};
                    end
                end
                EXEC: begin
                    res_r   <= res_nxt_s;
                    carry_r <= alu_cout;
                    a_sh_r  <= a_sh_r >> 8;
                    b_sh_r  <= b_sh_r >> 8;
                    // Holding the counter on the final lane keeps it from wrapping at NBYTES=8.
                    if (last_lane_s) begin
                        rsp_f_r    <= res_nxt_s;
                        rsp_cout_r <= alu_cout;
`ifdef ALU_SEQ_OVF_EN
                        rsp_ovf_r  <= ovf_calc(op_r, a_sh_r[7:0], b_sh_r[7:0], alu_f);
`endif
                    end else begin
                        lane_r <= lane_r + 3'd1;
                    end
                end
                DONE: begin
                    lane_r <= lane_r;
                end
                default: begin
                    lane_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural 8-bit ALU and a result scoreboard.
module tb_alu_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic         req_cin;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
`ifdef ALU_SEQ_OVF_EN
    logic         rsp_ovf;
`endif
    logic         busy;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_s1;
    logic         alu_s0;
    logic         alu_cin;
    logic [7:0]   alu_f;
    logic         alu_cout;
    logic [8:0]   alu_sum;

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic [1:0]   cur_op;
    logic         cur_cin;

    alu_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_OVF_EN
        .rsp_ovf(rsp_ovf),
`endif
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU.
    always_comb begin
        case ({alu_s1, alu_s0})
            2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            2'b01:   alu_sum = {1'b0, alu_a} + {8'd0, alu_cin};
            2'b10:   alu_sum = {1'b0, ~alu_b} + {8'd0, alu_cin};
            2'b11:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            default: alu_sum = 9'd0;
        endcase
    end
    assign alu_f    = alu_sum[7:0];
    assign alu_cout = alu_sum[8];

    // Full-width reference: the lane ripple equals one W-bit operation.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic cin);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   s;
        exp_t         m;
        case (op)
            2'b00:   begin x = a;  y = b;         end
            2'b01:   begin x = a;  y = {W{1'b0}}; end
            2'b10:   begin x = ~b; y = {W{1'b0}}; end
            default: begin x = a;  y = ~b;        end
        endcase
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        m.f    = s[W-1:0];
        m.cout = s[W];
        m.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin);
        int n = 0;
        req_a = a; req_b = b; req_op = op; req_cin = cin; req_valid = 1'b1;
        cur_a = a; cur_b = b; cur_op = op; cur_cin = cin;
        while (!req_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        exp_q.push_back(model(a, b, op, cin));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic lanes();
        for (int k = 0; k < NBYTES; k++) begin
            chk("lane_a", {56'd0, alu_a}, {56'd0, cur_a[k*8 +: 8]});
            chk("lane_b", {56'd0, alu_b}, {56'd0, cur_b[k*8 +: 8]});
            chk("lane_op", {62'd0, alu_s1, alu_s0}, {62'd0, cur_op});
            if (k == 0) chk("lane0_cin", {63'd0, alu_cin}, {63'd0, cur_cin});
            chk("exec_no_valid", {63'd0, rsp_valid}, 64'd0);
            @(posedge clk); #1;
        end
        chk("latency_valid", {63'd0, rsp_valid}, 64'd1);
        chk("done_alu_zero", {45'd0, alu_a, alu_b, alu_s1, alu_s0, alu_cin}, 64'd0);
    endtask

    task automatic recv();
        int   n = 0;
        exp_t e;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
        chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_f", {32'd0, rsp_f}, {32'd0, e.f});
            chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
`ifdef ALU_SEQ_OVF_EN
            chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
`endif
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("ready_back", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic op_run(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin);
        accept(a, b, op, cin);
        lanes();
        recv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic seen;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_cin = 1'b0;
        req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_f", {32'd0, rsp_f}, 64'd0);
        chk("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_alu", {45'd0, alu_a, alu_b, alu_s1, alu_s0, alu_cin}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases.
        op_run(32'h000000FF, 32'h00000001, 2'b00, 1'b0);
        op_run(32'h00000000, 32'h00000001, 2'b11, 1'b1);
        op_run(32'h00000005, 32'h00000003, 2'b11, 1'b1);
        op_run(32'h12345678, 32'h00000000, 2'b10, 1'b1);
        op_run(32'hFFFFFFFF, 32'h00000000, 2'b01, 1'b1);
        op_run(32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0);
        op_run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0);
        op_run(32'h80000000, 32'h00000001, 2'b11, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op_run($urandom, $urandom, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        // Backpressure with a second request waiting.
        accept(32'h0000FFFF, 32'h00000001, 2'b00, 1'b0);
        lanes();
        e = exp_q[0];
        req_a = 32'h00000010; req_b = 32'h00000004; req_op = 2'b11; req_cin = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_f", {32'd0, rsp_f}, {32'd0, e.f});
            chk("bp_rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        rsp_ready = 1'b0;
        chk("bp_rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("bp_ready_idle", {63'd0, req_ready}, 64'd1);
        cur_a = req_a; cur_b = req_b; cur_op = req_op; cur_cin = req_cin;
        exp_q.push_back(model(req_a, req_b, req_op, req_cin));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {63'd0, busy}, 64'd1);
        lanes();
        recv();

        // Reset during lane 2.
        accept(32'hA5A55A5A, 32'h0F0F0F0F, 2'b00, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_lane2_a", {56'd0, alu_a}, {56'd0, cur_a[23:16]});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_alu", {45'd0, alu_a, alu_b, alu_s1, alu_s0, alu_cin}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        e = exp_q.pop_back();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", {63'd0, seen}, 64'd0);
        op_run(32'h00FF00FF, 32'h00010001, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
